// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID register for the SIMD AES core: PC generation, single-outstanding
// imem handshake, redirect/flush, one-entry skid buffer and OpCode/P1/P2 field split.
module fetch_decode_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_instr,
  output logic [0:4]        OpCode,
  output logic [0:14]       InstructionP1,
  output logic [0:9]        InstructionP2,
  output logic              id_illegal
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] inflight_pc, inflight_pc_nxt;
  logic              kill, kill_nxt;
  logic              fire;
  logic              rsp_vld_p0;
  logic [ADDR_W-1:0] redirect_aligned;

  logic              skid_vld_p1;
  logic [ADDR_W-1:0] skid_pc_p1;
  logic [31:0]       skid_instr_p1;

  logic              id_can_load;
  logic              id_load;
  logic              skid_load;

  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_aligned    = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Requests are withheld while the skid holds a word, so at most one response is ever unplaced.
  assign imem_req  = run && (state == ST_REQ) && !skid_vld_p1;
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inflight_pc_nxt = inflight_pc;
    kill_nxt        = kill;
    rsp_vld_p0      = 1'b0;
    case (state)
      ST_REQ: begin
        if (fire) begin
          inflight_pc_nxt = pc;
          pc_nxt          = pc + ADDR_W'(4);
          state_nxt       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          rsp_vld_p0 = !kill;
          kill_nxt   = 1'b0;
          state_nxt  = ST_REQ;
        end
      end
      default: state_nxt = ST_REQ;
    endcase
    // A grant taken in the redirect cycle still owes a response, which must be killed.
    if (redirect_valid) begin
      pc_nxt     = redirect_aligned;
      rsp_vld_p0 = 1'b0;
      if (state == ST_WAIT && !imem_rvalid) kill_nxt = 1'b1;
      if (state == ST_REQ && fire)          kill_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      run         <= 1'b0;
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      kill        <= 1'b0;
    end else begin
      state       <= state_nxt;
      run         <= 1'b1;
      pc          <= pc_nxt;
      inflight_pc <= inflight_pc_nxt;
      kill        <= kill_nxt;
    end
  end

  // p0 -> p1: response placement into the IF/ID register or the skid
  assign id_can_load = !id_valid || !id_stall;
  assign id_load     = !redirect_valid && id_can_load && (skid_vld_p1 || rsp_vld_p0);
  assign skid_load   = rsp_vld_p0 && (skid_vld_p1 ? id_can_load : !id_can_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_p1 <= 1'b0;
    end else if (redirect_valid) begin
      skid_vld_p1 <= 1'b0;
    end else if (id_load && skid_vld_p1) begin
      skid_vld_p1 <= skid_load;
    end else if (skid_load) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_pc_p1    <= inflight_pc;
      skid_instr_p1 <= imem_rdata;
    end
  end

  // p1 -> ID: the skid is older than any new response, so it drains first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= '0;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
    end else if (id_load) begin
      id_valid <= 1'b1;
      id_pc    <= skid_vld_p1 ? skid_pc_p1    : inflight_pc;
      id_instr <= skid_vld_p1 ? skid_instr_p1 : imem_rdata;
    end else if (!id_stall) begin
      id_valid <= 1'b0;
    end
  end

  assign OpCode        = id_instr[31:27];
  assign InstructionP1 = id_instr[26:12];
  assign InstructionP2 = id_instr[11:2];
  assign id_illegal    = id_valid && (id_instr[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: a memory model feeds randomized grants/latencies,
// stalls and redirects; expected fetch-order words are queued and checked as ID presents them.
module tb_fetch_decode_stage;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [0:4]  OpCode;
  logic [0:14] InstructionP1;
  logic [0:9]  InstructionP2;
  logic        id_illegal;

  always #5 clk = ~clk;

  fetch_decode_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .OpCode(OpCode), .InstructionP1(InstructionP1), .InstructionP2(InstructionP2),
    .id_illegal(id_illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a few fixed words, a hash elsewhere (some with illegal low bits).
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0:   h = 32'hC000_0000;
      32'h4:   h = 32'h4000_1234;
      32'h100: h = 32'h0000_0001;
      default: begin
        h = (a * 32'h9E37_79B1) ^ 32'h3C5A_0000;
        if (a[6:4] != 3'd5) h[1:0] = 2'b00;
      end
    endcase
    return h;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;
  item_t sb[$];

  // Driver / memory model state.  mode: 0 clean, 1 stall held, 2 random, 3 clean with 2-cycle latency
  bit          run = 1'b0;
  int          mode = 0;
  bit          outstanding;
  int          cnt;
  logic [31:0] out_addr;
  logic [31:0] model_pc;
  bit          prev_fire, prev_redir, prev_rv;
  logic [31:0] prev_addr, prev_rpc;
  bit          force_redir = 1'b0;
  bit          force_need_wait = 1'b0;
  logic [31:0] force_rpc = 32'h0;

  always @(posedge clk) begin
    #1;
    if (!run) begin
      outstanding = 1'b0;
      cnt         = 0;
      prev_fire   = 1'b0;
      prev_redir  = 1'b0;
      prev_rv     = 1'b0;
      model_pc    = RESET_PC;
      sb.delete();
    end else begin
      bit          g, rv, st, rd;
      logic [31:0] rpc;
      // account for the edge that just happened
      if (prev_redir) begin
        chk("flush_id_valid", {63'h0, id_valid}, 64'h0);
        sb.delete();
        model_pc = {prev_rpc[31:2], 2'b00};
      end else if (prev_fire) begin
        sb.push_back('{pc: prev_addr, instr: word_at(prev_addr)});
        model_pc = prev_addr + 32'd4;
      end
      if (prev_fire) begin
        outstanding = 1'b1;
        out_addr    = prev_addr;
        cnt         = (mode == 2) ? int'($urandom_range(0, 2)) : (mode == 3) ? 1 : 0;
      end else if (prev_rv) begin
        outstanding = 1'b0;
      end
      if (imem_req) begin
        chk("single_outstanding", {63'h0, outstanding}, 64'h0);
        chk("imem_addr", {32'h0, imem_addr}, {32'h0, model_pc});
      end
      g  = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
      rv = 1'b0;
      if (outstanding) begin
        if (cnt == 0) rv = 1'b1;
        else cnt--;
      end
      st  = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 9) < 3) : 1'b0;
      rd  = 1'b0;
      rpc = $urandom;
      if (force_redir && (!force_need_wait || (outstanding && !rv))) begin
        rd = 1'b1;
        rpc = force_rpc;
        force_redir = 1'b0;
      end else if (mode == 2 && $urandom_range(0, 99) < 3) begin
        rd  = 1'b1;
        rpc = $urandom & 32'h0000_0FFF;
      end
      imem_gnt       = g;
      imem_rvalid    = rv;
      imem_rdata     = rv ? word_at(out_addr) : $urandom;
      id_stall       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      prev_fire  = imem_req && g;
      prev_addr  = imem_addr;
      prev_redir = rd;
      prev_rpc   = rpc;
      prev_rv    = rv;
    end
  end

  // Monitor: a newly presented ID word is popped and compared; a held word must not change.
  bit    newflag = 1'b1;
  item_t cur = '0;

  always @(negedge clk) begin
    if (!rst_n || !run) begin
      newflag = 1'b1;
    end else begin
      if (id_valid) begin
        if (newflag) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_id: got pc %0h instr %0h, expected no instruction", id_pc, id_instr);
          end else begin
            cur = sb.pop_front();
            delivered++;
            chk("id_pc", {32'h0, id_pc}, {32'h0, cur.pc});
            chk("id_instr", {32'h0, id_instr}, {32'h0, cur.instr});
            chk("OpCode", {59'h0, OpCode}, {59'h0, cur.instr[31:27]});
            chk("OpCode0_msb", {63'h0, OpCode[0]}, {63'h0, cur.instr[31]});
            chk("InstructionP1", {49'h0, InstructionP1}, {49'h0, cur.instr[26:12]});
            chk("InstructionP2", {54'h0, InstructionP2}, {54'h0, cur.instr[11:2]});
            chk("id_illegal", {63'h0, id_illegal}, {63'h0, (cur.instr[1:0] != 2'b00)});
          end
        end else begin
          chk("hold_pc", {32'h0, id_pc}, {32'h0, cur.pc});
          chk("hold_instr", {32'h0, id_instr}, {32'h0, cur.instr});
        end
      end
      newflag = !id_valid || !id_stall || redirect_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_imem_req"}, {63'h0, imem_req}, 64'h0);
    chk({tag, "_id_valid"}, {63'h0, id_valid}, 64'h0);
    chk({tag, "_id_pc"}, {32'h0, id_pc}, 64'h0);
    chk({tag, "_id_instr"}, {32'h0, id_instr}, 64'h0);
    chk({tag, "_fields"}, {34'h0, OpCode, InstructionP1, InstructionP2}, 64'h0);
    chk({tag, "_id_illegal"}, {63'h0, id_illegal}, 64'h0);
  endtask

  // Release reset with a stray rvalid present, confirm the first request, then hand over to the driver.
  task automatic release_and_start();
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", {63'h0, imem_req}, 64'h1);
    chk("first_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});
    chk("stray_rvalid_ignored", {63'h0, id_valid}, 64'h0);
    imem_rvalid = 1'b0;
    @(negedge clk);
    run = 1'b1;
  endtask

  task automatic wait_force_done();
    int i;
    for (i = 0; i < 50 && force_redir; i++) @(negedge clk);
    chk("redirect_issued", {63'h0, force_redir}, 64'h0);
  endtask

  initial begin
    int i;
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_and_start();

    mode = 0;
    repeat (12) @(negedge clk);

    // Hold the stall long enough to fill ID and the skid, then release.
    mode = 1;
    repeat (10) @(negedge clk);
    chk("req_blocked_skid_full", {63'h0, imem_req}, 64'h0);
    mode = 0;
    repeat (12) @(negedge clk);

    // Redirect while waiting on a response, with an unaligned target.
    mode            = 3;
    force_need_wait = 1'b1;
    force_rpc       = 32'h0000_0103;
    force_redir     = 1'b1;
    wait_force_done();
    repeat (14) @(negedge clk);

    // Redirect with ID stalled and the skid full.
    mode = 1;
    repeat (10) @(negedge clk);
    force_need_wait = 1'b0;
    force_rpc       = 32'h0000_0200;
    force_redir     = 1'b1;
    wait_force_done();
    repeat (2) @(negedge clk);
    mode = 0;
    repeat (12) @(negedge clk);

    mode = 2;
    repeat (3000) @(negedge clk);

    // Asynchronous reset in the middle of an outstanding fetch.
    mode = 3;
    for (i = 0; i < 50 && !(outstanding && !imem_rvalid); i++) @(negedge clk);
    chk("reached_wait", {63'h0, (outstanding && !imem_rvalid)}, 64'h1);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check_all_zero("async_reset");
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1234_5678;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("held_reset");
    release_and_start();

    mode = 2;
    repeat (400) @(negedge clk);
    mode = 0;
    repeat (10) @(negedge clk);
    chk("delivered_enough", {63'h0, (delivered > 300)}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch and IF/ID pipeline stage of the SIMD AES core.
- Generates the PC and runs a single-outstanding-request handshake with instruction memory.
- Holds each fetched word in an IF/ID register, with stall, flush/redirect and a one-entry skid buffer.
- Splits the word into the OpCode, InstructionP1 and InstructionP2 fields consumed by the immediate generator and decode logic.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid, at least 1 cycle after gnt.
- imem_rdata  in  32  fetched instruction word.
- id_stall  in  1  downstream hold; the IF/ID register must not change.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored, forced to 0.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pc  out  ADDR_W  PC of the held instruction.
- id_instr  out  32  raw held word.
- OpCode  out  5  [0:4] = id_instr[31:27]; index 0 is the MSB.
- InstructionP1  out  15  [0:14] = id_instr[26:12].
- InstructionP2  out  10  [0:9] = id_instr[11:2].
- id_illegal  out  1  id_valid and id_instr[1:0] != 2'b00.

Behaviour:
- Reset, asynchronous on rst_n low, with immediate effect:
  - pc = RESET_PC; state = REQ; kill = 0; skid empty.
  - imem_req = 0; id_valid = 0; id_pc, id_instr and all field outputs = 0.
  - On the first clock after release, imem_req = 1.
- Fields are combinational slices of id_instr. They carry no extra latency and change only when the IF/ID register loads.
- State machine:
  - REQ:
    - imem_req = 1 only when the skid buffer is empty; imem_addr = pc.
    - On imem_gnt: capture pc into inflight_pc, pc <= pc + 4 (wraps modulo 2^ADDR_W), go to WAIT.
  - WAIT:
    - imem_req = 0.
    - On imem_rvalid with kill = 1: discard the data, clear kill, go to REQ.
    - On imem_rvalid with kill = 0: deliver {inflight_pc, imem_rdata}, go to REQ.
- Delivery rule: IF/ID can accept when id_valid = 0 or id_stall = 0.
  - Accept: load from skid if skid is full (skid then takes the new response), otherwise load from the response.
  - Cannot accept: the response goes into the skid.
- The skid is never overwritten while full. Requests are blocked while it is full, so this cannot happen.
- Advance: when id_stall = 0 and nothing is available to load, id_valid <= 0 on the edge. When id_stall = 1, all id_* outputs hold.
- Fetch-to-ID latency: 1 edge after rvalid when not stalled.
- Steady-state throughput: one instruction per 2 cycles when gnt is immediate.
- Redirect (redirect_valid = 1) has priority over everything, including id_stall:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; id_valid <= 0; skid cleared; any rvalid data arriving that same cycle is not delivered.
  - In WAIT without rvalid: kill <= 1; stay in WAIT.
  - In WAIT with rvalid: drop the data; go to REQ.
  - In REQ with imem_gnt the same cycle: the grant is consumed, go to WAIT with kill = 1, and pc still loads redirect_pc (not +4).
  - In REQ without gnt: stay in REQ; the next request uses the new pc.
- A redirect and an rvalid in the same cycle: the data is always dropped, never placed in ID or skid.
- Order guarantee: instructions reach ID strictly in fetch order, with no loss or duplication, except those flushed by a redirect.

Test Plan:
- Release reset, gnt always 1, rvalid 1 cycle after gnt, rdata = 0xC0000000 then 0x40001234 -> imem_addr 0x0, 0x4.
  - First ID: id_valid = 1, id_pc = 0x0, OpCode = 11000.
  - Second ID: id_pc = 0x4, OpCode = 01000, InstructionP2 = id_instr[11:2] = 0x08D.
- Hold id_stall = 1 across two responses -> ID outputs frozen; second word sits in skid; imem_req stays 0 while skid full. Release -> words at 0x4 and 0x8 appear in order, none lost or duplicated.
- In WAIT for addr 0x8, pulse redirect_valid with redirect_pc = 0x103 -> id_valid = 0 next edge; the 0x8 response is discarded; next request and next id_pc are 0x100.
- redirect_valid with id_stall = 1 and skid full -> id_valid = 0 and skid empty after one edge; fetch resumes at redirect_pc.
- rdata = 0x00000001 -> id_valid = 1, id_illegal = 1, InstructionP1 = 0, InstructionP2 = 0.
- Drop rst_n in WAIT mid-fetch -> all outputs 0 before the next edge; the late rvalid is ignored; after release the first imem_addr = RESET_PC.
